// File: rtl/vic_cfg_sequencer_if.sv
// Host-side bundle for vic_cfg_sequencer: command stream, write-data stream,
// read-data stream and status pulses.
interface vic_cfg_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err
  );
endinterface

// File: rtl/vic_cfg_sequencer.sv
// Burst command sequencer, sole master of the VIC configuration register-file port.
// Optional macro VIC_SEQ_AUTO_ENA_EN appends a global-enable write after WRITE/CLEAR bursts.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// WRITE    | one register write per accepted write-stream word
// CLEAR    | one register write of zero per cycle
// RD_ISSUE | drive read strobe for the current address
// RD_WAIT  | register file latches the read
// RD_OUT   | capture read data, hold it until the consumer takes it
// ENA      | extra write of 1 to the global-enable register (macro only)
// DONE     | completion pulse, back to IDLE
module vic_cfg_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int ENA_ADDR = 31
) (
  input  logic               clk,
  input  logic               rst,
  vic_cfg_sequencer_if.slave io_host,
  output logic [ADDR_W-1:0]  o_regaddr,
  output logic [DATA_W-1:0]  o_regdata,
  output logic               o_we,
  output logic               o_re,
  input  logic [DATA_W-1:0]  i_regdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_CLEAR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_OUT,
`ifdef VIC_SEQ_AUTO_ENA_EN
    S_ENA,
`endif
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_regaddr;
  logic [DATA_W-1:0] r_regdata;
  logic              r_we;
  logic              r_re;
  state_t            w_burst_next;

  // Where a WRITE/CLEAR burst goes after its last word.
`ifdef VIC_SEQ_AUTO_ENA_EN
  assign w_burst_next = S_ENA;
`else
  assign w_burst_next = S_DONE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_regaddr  <= '0;
      r_regdata  <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_host.cmd_valid) begin
            r_addr <= io_host.cmd_addr;
            r_rem  <= io_host.cmd_len;
            case (io_host.cmd_op)
              2'b00:   r_state <= S_WRITE;
              2'b01:   r_state <= S_RD_ISSUE;
              2'b10:   r_state <= S_CLEAR;
              default: r_err   <= 1'b1;
            endcase
          end
        end
        S_WRITE: begin
          if (io_host.wr_valid) begin
            r_we      <= 1'b1;
            r_regaddr <= r_addr;
            r_regdata <= io_host.wr_data;
            r_addr    <= r_addr + ADDR_W'(1);
            if (r_rem == '0) r_state <= w_burst_next;
            else             r_rem   <= r_rem - ADDR_W'(1);
          end
        end
        S_CLEAR: begin
          r_we      <= 1'b1;
          r_regaddr <= r_addr;
          r_regdata <= '0;
          r_addr    <= r_addr + ADDR_W'(1);
          if (r_rem == '0) r_state <= w_burst_next;
          else             r_rem   <= r_rem - ADDR_W'(1);
        end
        S_RD_ISSUE: begin
          r_re      <= 1'b1;
          r_regaddr <= r_addr;
          r_state   <= S_RD_WAIT;
        end
        S_RD_WAIT: r_state <= S_RD_OUT;
        S_RD_OUT: begin
          // First cycle here is the one where the register file presents data.
          if (!r_rd_valid) begin
            r_rd_data  <= i_regdata;
            r_rd_valid <= 1'b1;
          end else if (io_host.rd_ready) begin
            r_rd_valid <= 1'b0;
            r_addr     <= r_addr + ADDR_W'(1);
            if (r_rem == '0) begin
              r_state <= S_DONE;
            end else begin
              r_rem   <= r_rem - ADDR_W'(1);
              r_state <= S_RD_ISSUE;
            end
          end
        end
`ifdef VIC_SEQ_AUTO_ENA_EN
        S_ENA: begin
          r_we      <= 1'b1;
          r_regaddr <= ADDR_W'(ENA_ADDR);
          r_regdata <= DATA_W'(1);
          r_state   <= S_DONE;
        end
`endif
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_host.cmd_ready = (r_state == S_IDLE);
  assign io_host.wr_ready  = (r_state == S_WRITE);
  assign io_host.busy      = (r_state != S_IDLE);
  assign io_host.rd_data   = r_rd_data;
  assign io_host.rd_valid  = r_rd_valid;
  assign io_host.done      = r_done;
  assign io_host.err       = r_err;
  assign o_regaddr         = r_regaddr;
  assign o_regdata         = r_regdata;
  assign o_we              = r_we;
  assign o_re              = r_re;

endmodule

// File: tb/tb_vic_cfg_sequencer.sv
// Testbench for vic_cfg_sequencer: register-file model, burst reference model,
// directed and randomized scenarios.
module tb_vic_cfg_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] o_regaddr;
  logic [3:0] o_regdata;
  logic       o_we;
  logic       o_re;
  logic [3:0] i_regdata;

`ifdef VIC_SEQ_AUTO_ENA_EN
  localparam bit AUTO_ENA = 1'b1;
`else
  localparam bit AUTO_ENA = 1'b0;
`endif

  vic_cfg_sequencer_if #(.ADDR_W(5), .DATA_W(4)) host ();

  vic_cfg_sequencer dut (
    .clk(clk), .rst(rst), .io_host(host),
    .o_regaddr(o_regaddr), .o_regdata(o_regdata),
    .o_we(o_we), .o_re(o_re), .i_regdata(i_regdata)
  );

  always #5 clk = ~clk;

  // Register file: write on strobe, read data valid the cycle after o_re.
  logic [3:0] mem [32];
  logic [3:0] rdq;
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 4'h0;
      rdq <= 4'h0;
    end else begin
      if (o_we) mem[o_regaddr] <= o_regdata;
      if (o_re) rdq <= mem[o_regaddr];
    end
  end
  assign i_regdata = rdq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_a[$], we_d[$], we_c[$];
  int re_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_we) begin
      we_a.push_back(int'(o_regaddr));
      we_d.push_back(int'(o_regdata));
      we_c.push_back(cyc);
    end
    if (o_re) re_cnt <= re_cnt + 1;
    if (o_we && o_re) both_cnt <= both_cnt + 1;
    if (host.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (host.err) err_cnt <= err_cnt + 1;
  end

  // Reference model state
  int         ref_mem [32];
  int         exp_a[$], exp_d[$], exp_rd[$];
  logic [3:0] wdata_q[$];
  int         rd_got[$];
  int         stab_bad;

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout got=no_event exp=event", name);
  endtask

  // Burst effect from the rules: words land at (addr+i) mod 32, then optional enable write.
  task automatic model_write_burst(input int a, input int len, input bit clr);
    exp_a.delete();
    exp_d.delete();
    for (int i = 0; i <= len; i++) begin
      int ad;
      int dv;
      ad = (a + i) % 32;
      dv = clr ? 0 : int'(wdata_q[i]);
      exp_a.push_back(ad);
      exp_d.push_back(dv);
      ref_mem[ad] = dv;
    end
    if (AUTO_ENA) begin
      exp_a.push_back(31);
      exp_d.push_back(1);
      ref_mem[31] = 1;
    end
  endtask

  task automatic model_read_burst(input int a, input int len);
    exp_rd.delete();
    for (int i = 0; i <= len; i++) exp_rd.push_back(ref_mem[(a + i) % 32]);
  endtask

  task automatic send_cmd(input logic [1:0] op, input int a, input int len);
    int t;
    host.cmd_valid = 1'b1;
    host.cmd_op    = op;
    host.cmd_addr  = 5'(a);
    host.cmd_len   = 5'(len);
    t = 0;
    @(negedge clk);
    while (!host.cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!host.cmd_ready) fail_timeout("cmd_accept");
    @(posedge clk); #1;
    host.cmd_valid = 1'b0;
  endtask

  task automatic feed_words(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      int t;
      int gap;
      gap = rnd ? int'($urandom_range(0, 2)) : 0;
      host.wr_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      host.wr_valid = 1'b1;
      host.wr_data  = wdata_q[i];
      t = 0;
      @(negedge clk);
      while (!host.wr_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!host.wr_ready) begin
        fail_timeout("wr_accept");
        host.wr_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    host.wr_valid = 1'b0;
  endtask

  task automatic read_words(input int n, input int hold, input bit rnd);
    for (int i = 0; i < n; i++) begin
      int t;
      int h;
      logic [3:0] first;
      t = 0;
      @(negedge clk);
      while (!host.rd_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!host.rd_valid) begin
        fail_timeout("rd_valid");
        return;
      end
      first = host.rd_data;
      rd_got.push_back(int'(first));
      h = rnd ? int'($urandom_range(0, 3)) : hold;
      repeat (h) begin
        @(posedge clk);
        @(negedge clk);
        if (host.rd_data !== first || host.rd_valid !== 1'b1) stab_bad++;
      end
      @(posedge clk); #1;
      host.rd_ready = 1'b1;
      @(negedge clk);
      if (host.rd_data !== first || host.rd_valid !== 1'b1) stab_bad++;
      @(posedge clk); #1;
      host.rd_ready = 1'b0;
    end
  endtask

  task automatic wait_done(input int prev);
    int t;
    t = 0;
    while (done_cnt == prev && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == prev) fail_timeout("done");
    #1;
  endtask

  task automatic run_burst(input logic [1:0] op, input int a, input int len,
                           input bit rnd, input int hold);
    int prev;
    prev = done_cnt;
    we_a.delete(); we_d.delete(); we_c.delete();
    rd_got.delete();
    stab_bad = 0;
    send_cmd(op, a, len);
    if (op == 2'b00) feed_words(len + 1, rnd);
    if (op == 2'b01) read_words(len + 1, hold, rnd);
    wait_done(prev);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({host.cmd_ready, host.busy, host.done, host.err, host.wr_ready, host.rd_valid} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_status got=%b exp=100000",
               {host.cmd_ready, host.busy, host.done, host.err, host.wr_ready, host.rd_valid});
    end
    checks++;
    if ({o_we, o_re, o_regaddr, o_regdata, host.rd_data} !== 15'd0) begin
      failures++;
      $display("FAIL reset_regport got=%0h exp=0", {o_we, o_re, o_regaddr, o_regdata, host.rd_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_write_burst;
    int dprev;
    int last;
    wdata_q = '{4'h5, 4'hA, 4'h3};
    model_write_burst(2, 2, 1'b0);
    dprev = done_cnt;
    run_burst(2'b00, 2, 2, 1'b0, 0);
    checks++;
    if (we_a.size() !== exp_a.size()) begin
      failures++;
      $display("FAIL wr_count got=%0d exp=%0d", we_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < we_a.size(); i++) begin
      checks++;
      if (we_a[i] !== exp_a[i] || we_d[i] !== exp_d[i] || we_c[i] !== we_c[0] + i) begin
        failures++;
        $display("FAIL wr_word%0d got=a%0d/d%0d/c%0d exp=a%0d/d%0d/c%0d", i, we_a[i], we_d[i],
                 we_c[i], exp_a[i], exp_d[i], we_c[0] + i);
      end
    end
    last = (we_c.size() > 0) ? we_c[we_c.size() - 1] : -10;
    checks++;
    if (done_cyc !== last + 1 || done_cnt !== dprev + 1) begin
      failures++;
      $display("FAIL wr_done got=cyc%0d/n%0d exp=cyc%0d/n%0d", done_cyc, done_cnt - dprev, last + 1, 1);
    end
  endtask

  task automatic test_read_burst;
    int rprev;
    int wn;
    rprev = re_cnt;
    model_read_burst(2, 2);
    run_burst(2'b01, 2, 2, 1'b0, 3);
    wn = we_a.size();
    checks++;
    if (rd_got.size() !== 3) begin
      failures++;
      $display("FAIL rd_count got=%0d exp=3", rd_got.size());
    end
    for (int i = 0; i < 3 && i < rd_got.size(); i++) begin
      checks++;
      if (rd_got[i] !== exp_rd[i]) begin
        failures++;
        $display("FAIL rd_word%0d got=%0h exp=%0h", i, rd_got[i], exp_rd[i]);
      end
    end
    checks++;
    if (re_cnt - rprev !== 3 || wn !== 0 || stab_bad !== 0) begin
      failures++;
      $display("FAIL rd_strobes got=re%0d/we%0d/unstable%0d exp=re3/we0/unstable0",
               re_cnt - rprev, wn, stab_bad);
    end
  endtask

  task automatic test_wrap;
    int bad;
    wdata_q.delete();
    for (int i = 0; i < 4; i++) wdata_q.push_back(4'($urandom_range(0, 15)));
    model_write_burst(30, 3, 1'b0);
    run_burst(2'b00, 30, 3, 1'b1, 0);
    checks++;
    if (we_a.size() !== exp_a.size()) begin
      failures++;
      $display("FAIL wrap_count got=%0d exp=%0d", we_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < we_a.size(); i++) begin
      checks++;
      if (we_a[i] !== exp_a[i] || we_d[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL wrap_word%0d got=a%0d/d%0d exp=a%0d/d%0d", i, we_a[i], we_d[i], exp_a[i], exp_d[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (int'(mem[i]) !== ref_mem[i]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL wrap_regfile got=%0d_bad_entries exp=0", bad);
    end
  endtask

  task automatic test_clear;
    int prev;
    int busy_accept;
    prev = done_cnt;
    model_write_burst(0, 31, 1'b1);
    we_a.delete(); we_d.delete(); we_c.delete();
    send_cmd(2'b10, 0, 31);
    repeat (4) @(posedge clk);
    #1;
    host.cmd_valid = 1'b1;
    host.cmd_op    = 2'b00;
    busy_accept = 0;
    repeat (10) begin
      @(negedge clk);
      if (host.cmd_ready !== 1'b0) busy_accept++;
    end
    @(posedge clk); #1;
    host.cmd_valid = 1'b0;
    wait_done(prev);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy_accept !== 0) begin
      failures++;
      $display("FAIL clr_cmd_ready got=%0d_ready_cycles exp=0", busy_accept);
    end
    checks++;
    if (we_a.size() !== exp_a.size()) begin
      failures++;
      $display("FAIL clr_count got=%0d exp=%0d", we_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < we_a.size(); i++) begin
      checks++;
      if (we_a[i] !== exp_a[i] || we_d[i] !== exp_d[i] || we_c[i] !== we_c[0] + i) begin
        failures++;
        $display("FAIL clr_word%0d got=a%0d/d%0d/c%0d exp=a%0d/d%0d/c%0d", i, we_a[i], we_d[i],
                 we_c[i], exp_a[i], exp_d[i], we_c[0] + i);
      end
    end
    checks++;
    if (done_cnt !== prev + 1) begin
      failures++;
      $display("FAIL clr_done got=%0d exp=1", done_cnt - prev);
    end
  endtask

  task automatic test_reserved;
    int eprev, rprev, dprev;
    eprev = err_cnt; rprev = re_cnt; dprev = done_cnt;
    we_a.delete();
    send_cmd(2'b11, 7, 4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (err_cnt - eprev !== 1 || re_cnt !== rprev || we_a.size() !== 0 || done_cnt !== dprev) begin
      failures++;
      $display("FAIL reserved_op got=err%0d/re%0d/we%0d/done%0d exp=err1/re0/we0/done0",
               err_cnt - eprev, re_cnt - rprev, we_a.size(), done_cnt - dprev);
    end
    checks++;
    if (host.cmd_ready !== 1'b1 || host.busy !== 1'b0) begin
      failures++;
      $display("FAIL reserved_idle got=ready%b/busy%b exp=ready1/busy0", host.cmd_ready, host.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int a;
    int dprev;
    a = int'($urandom_range(0, 31));
    wdata_q.delete();
    for (int i = 0; i < 4; i++) wdata_q.push_back(4'($urandom_range(1, 15)));
    dprev = done_cnt;
    we_a.delete(); we_d.delete(); we_c.delete();
    send_cmd(2'b00, a, 3);
    feed_words(2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({host.cmd_ready, host.busy, host.done, host.wr_ready, host.rd_valid, o_we, o_re} !== 7'b1000000
        || o_regaddr !== 5'd0 || o_regdata !== 4'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b/a%0d/d%0d exp=1000000/a0/d0",
               {host.cmd_ready, host.busy, host.done, host.wr_ready, host.rd_valid, o_we, o_re},
               o_regaddr, o_regdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== dprev || we_a.size() !== 2) begin
      failures++;
      $display("FAIL rst_mid_abandon got=done%0d/we%0d exp=done0/we2", done_cnt - dprev, we_a.size());
    end
    for (int i = 0; i < 2 && i < we_a.size(); i++) begin
      ref_mem[(a + i) % 32] = int'(wdata_q[i]);
      checks++;
      if (we_a[i] !== (a + i) % 32 || we_d[i] !== int'(wdata_q[i])) begin
        failures++;
        $display("FAIL rst_mid_word%0d got=a%0d/d%0d exp=a%0d/d%0d", i, we_a[i], we_d[i],
                 (a + i) % 32, wdata_q[i]);
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      int op, a, len, rprev, dprev, bad;
      op  = int'($urandom_range(0, 2));
      a   = int'($urandom_range(0, 31));
      len = int'($urandom_range(0, 7));
      wdata_q.delete();
      for (int i = 0; i <= len; i++) wdata_q.push_back(4'($urandom_range(0, 15)));
      if (op == 1) model_read_burst(a, len);
      else         model_write_burst(a, len, op == 2);
      rprev = re_cnt;
      dprev = done_cnt;
      run_burst(2'(op), a, len, 1'b1, 0);
      if (op == 1) begin
        checks++;
        if (rd_got.size() !== len + 1 || re_cnt - rprev !== len + 1 || stab_bad !== 0) begin
          failures++;
          $display("FAIL rnd%0d_read got=n%0d/re%0d/unstable%0d exp=n%0d/re%0d/unstable0",
                   it, rd_got.size(), re_cnt - rprev, stab_bad, len + 1, len + 1);
        end
        for (int i = 0; i <= len && i < rd_got.size(); i++) begin
          checks++;
          if (rd_got[i] !== exp_rd[i]) begin
            failures++;
            $display("FAIL rnd%0d_rd%0d got=%0h exp=%0h", it, i, rd_got[i], exp_rd[i]);
          end
        end
      end else begin
        checks++;
        if (we_a.size() !== exp_a.size()) begin
          failures++;
          $display("FAIL rnd%0d_wcount got=%0d exp=%0d", it, we_a.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < we_a.size(); i++) begin
          checks++;
          if (we_a[i] !== exp_a[i] || we_d[i] !== exp_d[i]) begin
            failures++;
            $display("FAIL rnd%0d_w%0d got=a%0d/d%0d exp=a%0d/d%0d", it, i, we_a[i], we_d[i],
                     exp_a[i], exp_d[i]);
          end
        end
      end
      checks++;
      if (done_cnt - dprev !== 1) begin
        failures++;
        $display("FAIL rnd%0d_done got=%0d exp=1", it, done_cnt - dprev);
      end
      bad = 0;
      for (int i = 0; i < 32; i++) if (int'(mem[i]) !== ref_mem[i]) bad++;
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL rnd%0d_regfile got=%0d_bad_entries exp=0", it, bad);
      end
    end
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL we_re_overlap got=%0d exp=0", both_cnt);
    end
  endtask

  initial begin
    rst            = 1'b1;
    mem_init       = 1'b1;
    host.cmd_valid = 1'b0;
    host.cmd_op    = 2'b00;
    host.cmd_addr  = 5'd0;
    host.cmd_len   = 5'd0;
    host.wr_valid  = 1'b0;
    host.wr_data   = 4'h0;
    host.rd_ready  = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    test_reset;
    test_write_burst;
    test_read_burst;
    test_wrap;
    test_clear;
    test_reserved;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vic_cfg_sequencer.md
Name: vic_cfg_sequencer

Overview:
Burst command sequencer that owns the register-address/data/we/re port of the VIC configuration register file (32 x 4-bit, global enable in entry 31 bit 0).
Accepts host commands (write burst, read burst, clear range) with valid/ready streams for write and read data, and turns them into single-cycle register-file accesses.
Sits between the host interface logic and the configuration register file; it is the only master of that port.

Parameters:
ADDR_W, 5, register address width (32 entries)
DATA_W, 4, register data width
ENA_ADDR, 31, address of global-enable register

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
cmd_op  input  2  00 WRITE, 01 READ, 10 CLEAR, 11 reserved
cmd_addr  input  ADDR_W  start address
cmd_len  input  ADDR_W  burst length minus one (1..32 words)
wr_data  input  DATA_W  write stream data
wr_valid  input  1  write word offered
wr_ready  output  1  write word accepted
rd_data  output  DATA_W  read stream data (registered)
rd_valid  output  1  read word valid
rd_ready  input  1  read consumer ready
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at command completion
err  output  1  one-cycle pulse on reserved opcode
o_regaddr  output  ADDR_W  register-file address (registered)
o_regdata  output  DATA_W  register-file write data (registered)
o_we  output  1  register-file write strobe (registered, 1 cycle)
o_re  output  1  register-file read strobe (registered, 1 cycle)
i_regdata  input  DATA_W  register-file read data, valid the cycle after o_re

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready=1 (combinational, IDLE only); counters 0. Reset mid-burst abandons the burst, no done, no further we/re.
- States: IDLE, WRITE, CLEAR, RD_ISSUE, RD_WAIT, RD_OUT, ENA, DONE.
- IDLE: on cmd accept load addr_q=cmd_addr, rem_q=cmd_len; op 00->WRITE, 01->RD_ISSUE, 10->CLEAR, 11->stay IDLE, err=1 next cycle.
- WRITE: wr_ready=1. On wr_valid&&wr_ready: next cycle o_we=1, o_regaddr=addr_q, o_regdata=wr_data; addr_q+=1 mod 32; if rem_q==0 -> DONE (or ENA) else rem_q-=1. No handshake -> o_we=0.
- CLEAR: one write of 0 per cycle, same address/count rules, no handshake; 32-word clear takes 32 cycles.
- Read: RD_ISSUE drives o_re=1, o_regaddr=addr_q for the next cycle -> RD_WAIT (register file latches) -> next cycle captures i_regdata into rd_data, rd_valid=1 -> RD_OUT holds rd_data/rd_valid stable until rd_ready; on handshake rd_valid=0, addr_q+=1, rem_q==0 ? DONE : (rem_q-=1, RD_ISSUE). Minimum 4 cycles per word.
- Address wraps 31->0 within a burst (addr 30, len 3 writes 30,31,0,1).
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in every state but IDLE; command arriving at busy waits.
- o_we and o_re never asserted together.

Optional Feature:
Macro VIC_SEQ_AUTO_ENA_EN. Defined: after the last word of a WRITE or CLEAR burst, pass through ENA, which issues one extra write of 4'b0001 to ENA_ADDR (overriding any value written there during the burst), then DONE. READ is unaffected. Undefined: ENA state absent, burst goes directly to DONE; entry 31 holds exactly what the burst wrote.

Test Plan:
- Reset, then WRITE addr=2 len=2 data 5,A,3 with wr_valid held -> o_we pulses at addrs 2,3,4 with 5,A,3 on consecutive cycles; done one cycle after last o_we.
- READ addr=2 len=2 with rd_ready low 3 cycles per word -> rd_data 5,A,3 each held stable while rd_valid high; o_re exactly 3 pulses; done once.
- WRITE addr=30 len=3 -> writes at 30,31,0,1 (wrap); with VIC_SEQ_AUTO_ENA_EN an extra write 1 to addr 31 follows, without it none.
- CLEAR addr=0 len=31 -> 32 consecutive o_we with data 0, addrs 0..31, then done; cmd_valid during burst not accepted (cmd_ready=0).
- cmd_op=11 -> err pulse 1 cycle, no o_we/o_re, cmd_ready stays 1.
- rst asserted mid WRITE after 2 of 4 words -> all outputs 0 next cycle, no done, IDLE with cmd_ready=1.
